uart_recv: RTL and testbench

8N1 UART receiver: the downstream counterpart of `uart_send`, consuming the serial line that `uart_send` drives. It synchronises the asynchronous `uart_rxd_i` input and detects a start-bit falling edge. It samples each bit at its mid-point, then presents the received byte with a one-cycle done strobe. A bad stop bit raises a frame-error strobe instead.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 40 ++++
 rtl/uart_recv.sv | 123 ++++++++++++
 tb/tb_uart_recv.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : uart_pkg
// Shared UART definitions: FSM state encoding, baud divisor helper, frame size.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Start + 8 data + stop
  localparam int unsigned c_frame_len = 10;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_rx_sync
// Two-flop synchroniser for the serial line plus history flop for edge detect.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rxd_i,
  output logic rxd_s,
  output logic fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_hist;
  logic [2:0] r_vld;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 1'b1;
      r_vld  <= 3'b000;
    end else begin
      r_meta <= rxd_i;
      r_sync <= r_meta;
      r_hist <= r_sync;
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  end

  // Edges are only trusted once the history flop holds a real line sample,
  // so a line already low when reset releases never looks like a start edge.
  assign rxd_s = r_sync;
  assign fall  = r_vld[2] & r_hist & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_recv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_recv
// 8N1 UART receiver: mid-bit sampling, done strobe on good frame, ferr on bad stop.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       uart_rxd_i,
  output logic [7:0] uart_dout_o,
  output logic       uart_done_o,
  output logic       uart_ferr_o,
  output logic       uart_rx_busy_o
);

  localparam int unsigned BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned HALF_CNT = BPS_CNT / 2;

  if (BPS_CNT < 4 || BPS_CNT >= 65536) begin : g_bad_bps_cnt
    $error("uart_recv: CLK_FREQ/UART_BPS must be in [4, 65535]");
  end

  localparam logic [15:0] c_bps_last  = 16'(BPS_CNT - 1);
  localparam logic [15:0] c_half_last = 16'(HALF_CNT - 1);

  logic        w_rxd_s;
  logic        w_fall;

  uart_state_e r_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_dout;
  logic        r_done;
  logic        r_ferr;

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rxd_i   (uart_rxd_i),
    .rxd_s   (w_rxd_s),
    .fall    (w_fall)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_clk_cnt <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_dout    <= 8'h00;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state   <= START;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
          end
        end
        START: begin
          if (r_clk_cnt == c_half_last) begin
            r_state   <= w_rxd_s ? IDLE : DATA;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_clk_cnt == c_bps_last) begin
            r_clk_cnt          <= 16'd0;
            r_shift[r_bit_cnt] <= w_rxd_s;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        STOP: begin
          // Leave at the stop-bit mid-point so a back-to-back start edge is caught.
          if (r_clk_cnt == c_bps_last) begin
            r_state   <= IDLE;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
            if (w_rxd_s) begin
              r_dout <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_cnt <= 16'd0;
          r_bit_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign uart_dout_o    = r_dout;
  assign uart_done_o    = r_done;
  assign uart_ferr_o    = r_ferr;
  assign uart_rx_busy_o = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_uart_recv
// Directed self-checking bench for uart_recv with a behavioural 8N1 line driver.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_uart_recv;

  // 160 Hz / 10 Bd: 16 clocks per bit, half bit 8
  localparam int unsigned CLK_FREQ = 160;
  localparam int unsigned UART_BPS = 10;
  localparam int BPS  = 16;
  localparam int HALF = 8;
  // Strobe registered at the stop-sample edge t0+3+HALF+9*BPS-1
  localparam int LAT  = 3 + HALF + 9 * BPS - 1;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] dout;
  logic       done;
  logic       ferr;
  logic       busy;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int strobe_err = 0;
  int last_done_cyc = 0;
  int last_ferr_cyc = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] rx_q[$];

  uart_recv #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .uart_rxd_i     (rxd),
    .uart_dout_o    (dout),
    .uart_done_o    (done),
    .uart_ferr_o    (ferr),
    .uart_rx_busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        rx_q.push_back(dout);
      end
      if (ferr) begin
        ferr_cnt++;
        last_ferr_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done && ferr) strobe_err++;
      if ((done && prev_done) || (ferr && prev_ferr)) strobe_err++;
    end
    prev_done = done;
    prev_ferr = ferr;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, output int t0);
    rxd = 1'b0;
    t0  = cyc + 1;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BPS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    tot_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else pass_cnt++;
    tot_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    tot_cnt++; if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ferr); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] vec [2] = '{8'h55, 8'hA3};
    logic [7:0] got;
    int t0, d0, f0;
    f0 = ferr_cnt;
    foreach (vec[k]) begin
      d0 = done_cnt;
      send_byte(vec[k], 1'b1, t0);
      repeat (4) @(negedge clk);
      tot_cnt++;
      if (done_cnt - d0 !== 1) $display("FAIL loop_done_cnt[%0d]: got %0d want 1", k, done_cnt - d0);
      else pass_cnt++;
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tot_cnt++;
      if (got !== vec[k]) $display("FAIL loop_byte[%0d]: got %h want %h", k, got, vec[k]);
      else pass_cnt++;
      tot_cnt++;
      if (last_done_cyc - t0 !== LAT)
        $display("FAIL loop_latency[%0d]: got %0d want %0d", k, last_done_cyc - t0, LAT);
      else pass_cnt++;
      tot_cnt++;
      if (dout !== vec[k]) $display("FAIL loop_dout[%0d]: got %h want %h", k, dout, vec[k]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (ferr_cnt - f0 !== 0) $display("FAIL loop_no_ferr: got %0d want 0", ferr_cnt - f0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3] = '{8'h00, 8'hFF, 8'h80};
    logic [7:0] got;
    int t0, d0;
    rx_q.delete();
    d0 = done_cnt;
    foreach (vec[k]) send_byte(vec[k], 1'b1, t0);
    repeat (4) @(negedge clk);
    tot_cnt++;
    if (done_cnt - d0 !== 3) $display("FAIL b2b_done_cnt: got %0d want 3", done_cnt - d0);
    else pass_cnt++;
    foreach (vec[k]) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tot_cnt++;
      if (got !== vec[k]) $display("FAIL b2b_byte[%0d]: got %h want %h", k, got, vec[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    int d0, f0, b0;
    logic [7:0] dout0;
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt; dout0 = dout;
    rxd = 1'b0;
    repeat (BPS / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    tot_cnt++;
    if (busy_cnt - b0 !== HALF) $display("FAIL glitch_busy_len: got %0d want %0d", busy_cnt - b0, HALF);
    else pass_cnt++;
    tot_cnt++;
    if (done_cnt - d0 !== 0) $display("FAIL glitch_no_done: got %0d want 0", done_cnt - d0);
    else pass_cnt++;
    tot_cnt++;
    if (ferr_cnt - f0 !== 0) $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt - f0);
    else pass_cnt++;
    tot_cnt++;
    if (dout !== dout0) $display("FAIL glitch_dout: got %h want %h", dout, dout0);
    else pass_cnt++;
  endtask

  task automatic test_frame_error();
    int t0, d0, f0, b0;
    send_byte(8'h3C, 1'b1, t0);
    repeat (4) @(negedge clk);
    tot_cnt++;
    if (dout !== 8'h3C) $display("FAIL ferr_good_dout: got %h want 3c", dout); else pass_cnt++;
    rx_q.delete();
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h99, 1'b0, t0);
    b0 = busy_cnt;
    repeat (3 * BPS) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    tot_cnt++;
    if (ferr_cnt - f0 !== 1) $display("FAIL ferr_cnt: got %0d want 1", ferr_cnt - f0); else pass_cnt++;
    tot_cnt++;
    if (last_ferr_cyc - t0 !== LAT)
      $display("FAIL ferr_latency: got %0d want %0d", last_ferr_cyc - t0, LAT);
    else pass_cnt++;
    tot_cnt++;
    if (done_cnt - d0 !== 0) $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0); else pass_cnt++;
    tot_cnt++;
    if (dout !== 8'h3C) $display("FAIL ferr_dout_held: got %h want 3c", dout); else pass_cnt++;
    tot_cnt++;
    if (busy_cnt - b0 !== 0) $display("FAIL ferr_low_line_start: got %0d busy cycles want 0", busy_cnt - b0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h5A;
    logic [7:0] got;
    int t0, d0, b0;
    rxd = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (BPS) @(negedge clk);
    end
    rxd = d[4];
    repeat (BPS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tot_cnt++; if (dout !== 8'h00) $display("FAIL rstmid_dout: got %h want 00", dout); else pass_cnt++;
    tot_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else pass_cnt++;
    tot_cnt++; if (ferr !== 1'b0) $display("FAIL rstmid_ferr: got %b want 0", ferr); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    b0 = busy_cnt;
    rst_n = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    tot_cnt++;
    if (busy_cnt - b0 !== 0) $display("FAIL rstmid_low_start: got %0d busy cycles want 0", busy_cnt - b0);
    else pass_cnt++;
    rxd = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    rx_q.delete();
    d0 = done_cnt;
    send_byte(8'hC3, 1'b1, t0);
    repeat (4) @(negedge clk);
    tot_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL rstmid_done_cnt: got %0d want 1", done_cnt - d0); else pass_cnt++;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    tot_cnt++;
    if (got !== 8'hC3) $display("FAIL rstmid_byte: got %h want c3", got); else pass_cnt++;
  endtask

  task automatic test_strobe_rules();
    tot_cnt++;
    if (strobe_err !== 0) $display("FAIL strobe_overlap: got %0d violations want 0", strobe_err);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_strobe_rules();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
